// File: rtl/sprite_compositor_if.sv
// Video-timing, sprite-state, block-memory and pixel-output bundle of the sprite compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = 17
);
  logic                                valid;
  logic [9:0]                          h_cnt;
  logic [9:0]                          v_cnt;
  logic                                frame_start;
  logic [NUM_SPRITES-1:0][9:0]         pos_h;
  logic [NUM_SPRITES-1:0][9:0]         pos_v;
  logic [NUM_SPRITES-1:0]              spr_en;
  logic [NUM_SPRITES-1:0]              anim_en;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0]  spr_addr;
  logic [NUM_SPRITES-1:0][11:0]        spr_pixel;
  logic [11:0]                         rgb;
  logic                                rgb_valid;
  logic [NUM_SPRITES-1:0]              collide;

  modport master (
    output valid, h_cnt, v_cnt, frame_start, pos_h, pos_v, spr_en, anim_en, spr_pixel,
    input  spr_addr, rgb, rgb_valid, collide
  );

  modport slave (
    input  valid, h_cnt, v_cnt, frame_start, pos_h, pos_v, spr_en, anim_en, spr_pixel,
    output spr_addr, rgb, rgb_valid, collide
  );
endinterface

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: per-sprite address generation and animation, colour-key
// transparency, fixed priority (index 0 on top) and a per-frame collision report.

module sprite_compositor_lane #(
  parameter int          SPR_W     = 20,
  parameter int          SPR_H     = 20,
  parameter int          FRAMES    = 4,
  parameter int          FW        = 2,
  parameter int          ADDR_W    = 17,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic              i_anim_step,
  input  logic [9:0]        i_pos_h,
  input  logic [9:0]        i_pos_v,
  input  logic              i_en,
  input  logic              i_anim_en,
  input  logic [9:0]        i_h,
  input  logic [9:0]        i_v,
  input  logic [11:0]       i_pixel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_opaque
);
  logic [9:0]        r_pos_h, r_pos_v;
  logic              r_en, r_anim;
  logic [FW-1:0]     r_frame;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_in_pipe;
  logic [10:0]       w_h, w_v, w_x0, w_y0, w_dx, w_dy;
  logic              w_inside;
  logic [ADDR_W-1:0] w_addr;

  assign w_h  = {1'b0, i_h};
  assign w_v  = {1'b0, i_v};
  assign w_x0 = {1'b0, r_pos_h};
  assign w_y0 = {1'b0, r_pos_v};
  assign w_dx = w_h - w_x0;
  assign w_dy = w_v - w_y0;

  // 11-bit bounds: a sprite hanging off the right/bottom edge clips rather than wrapping
  assign w_inside = r_en
                 && (w_h >= w_x0) && (w_h <= w_x0 + 11'(SPR_W - 1))
                 && (w_v >= w_y0) && (w_v <= w_y0 + 11'(SPR_H - 1));

  assign w_addr = ADDR_W'(r_frame) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(w_dy) * ADDR_W'(SPR_W)
                + ADDR_W'(w_dx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos_h   <= '0;
      r_pos_v   <= '0;
      r_en      <= 1'b0;
      r_anim    <= 1'b0;
      r_frame   <= '0;
      r_addr    <= '0;
      r_in_pipe <= '0;
    end else begin
      if (i_frame_start) begin
        r_pos_h <= i_pos_h;
        r_pos_v <= i_pos_v;
        r_en    <= i_en;
        r_anim  <= i_anim_en;
        // r_anim here is still last frame's shadow, so the step honours the old enable
        if (i_anim_step && r_anim)
          r_frame <= (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + FW'(1);
      end
      r_addr    <= w_inside ? w_addr : '0;
      r_in_pipe <= {r_in_pipe[0], w_inside};
    end
  end

  assign o_addr   = r_addr;
  assign o_opaque = r_in_pipe[1] && (i_pixel != KEY_COLOR);
endmodule

module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_W       = 20,
  parameter int          SPR_H       = 20,
  parameter int          FRAMES      = 4,
  parameter int          ANIM_DIV    = 8,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] KEY_COLOR   = 12'hF0F,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  sprite_compositor_if.slave  sif
);
  localparam int FW     = (FRAMES > 1)   ? $clog2(FRAMES)   : 1;
  localparam int DW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int STAGES = 2;

  logic [DW-1:0]                      r_div;
  logic                               w_step;
  logic [STAGES:0]                    r_vld_pipe;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0] w_addr;
  logic [NUM_SPRITES-1:0]             w_opaque, w_contrib, r_acc, r_collide;
  logic                               w_multi;
  logic [11:0]                        w_pix, r_rgb;

  assign w_step = sif.frame_start && (r_div == DW'(ANIM_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_div <= '0;
    else if (sif.frame_start) r_div <= w_step ? '0 : r_div + DW'(1);
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
    sprite_compositor_lane #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .FW(FW),
      .ADDR_W(ADDR_W), .KEY_COLOR(KEY_COLOR)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .i_frame_start (sif.frame_start),
      .i_anim_step   (w_step),
      .i_pos_h       (sif.pos_h[i]),
      .i_pos_v       (sif.pos_v[i]),
      .i_en          (sif.spr_en[i]),
      .i_anim_en     (sif.anim_en[i]),
      .i_h           (sif.h_cnt),
      .i_v           (sif.v_cnt),
      .i_pixel       (sif.spr_pixel[i]),
      .o_addr        (w_addr[i]),
      .o_opaque      (w_opaque[i])
    );
  end

  // Walk from lowest priority up so sprite 0 has the last word
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (w_opaque[i]) w_pix = sif.spr_pixel[i];
  end

  // x & (x-1) is non-zero exactly when two or more bits are set
  assign w_multi   = |(w_opaque & (w_opaque - NUM_SPRITES'(1)));
  assign w_contrib = (r_vld_pipe[1] && w_multi) ? w_opaque : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_rgb      <= '0;
      r_acc      <= '0;
      r_collide  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], sif.valid};
      r_rgb      <= r_vld_pipe[1] ? w_pix : '0;
      if (sif.frame_start) begin
        r_collide <= r_acc;
        r_acc     <= w_contrib;
      end else begin
        r_acc     <= r_acc | w_contrib;
      end
    end
  end

  assign sif.spr_addr  = w_addr;
  assign sif.rgb       = r_rgb;
  assign sif.rgb_valid = r_vld_pipe[STAGES];
  assign sif.collide   = r_collide;

  a_addr_fit: assert property (@(posedge clk) (FRAMES * SPR_W * SPR_H) <= (2 ** ADDR_W));
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: position/address, latency, priority, key, animation,
// tearing, edge clipping, collision and async reset, against hand-computed values.
module tb_sprite_compositor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] pix_val [4];
  int n_chk = 0;
  int n_fail = 0;

  sprite_compositor_if #(.NUM_SPRITES(4), .ADDR_W(17)) sif ();

  sprite_compositor dut (.clk(clk), .rst(rst), .sif(sif));

  always #5 clk = ~clk;

  // Block memory stand-in: one-cycle read latency, one constant colour per sprite
  always @(posedge clk)
    for (int i = 0; i < 4; i++) sif.spr_pixel[i] <= pix_val[i];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sif.valid = 1'b0;
    sif.h_cnt = 10'd0;
    sif.v_cnt = 10'd0;
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en, input bit an,
                         input logic [11:0] px);
    sif.pos_h[i]   = 10'(x);
    sif.pos_v[i]   = 10'(y);
    sif.spr_en[i]  = en;
    sif.anim_en[i] = an;
    pix_val[i]     = px;
  endtask

  task automatic fs(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); sif.frame_start = 1'b1;
      @(negedge clk); sif.frame_start = 1'b0;
    end
  endtask

  // One pixel in, then idle: addr one cycle later, rgb exactly three cycles later
  task automatic probe(input string tag, input int s, input int h, input int v, input bit vld,
                       input int ea, input int er);
    @(negedge clk);
    sif.h_cnt = 10'(h); sif.v_cnt = 10'(v); sif.valid = vld;
    @(negedge clk);
    chk({tag, ".addr"}, 32'(sif.spr_addr[s]), 32'(ea));
    idle();
    @(negedge clk);
    chk({tag, ".early"}, 32'(sif.rgb_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".rgb"}, 32'(sif.rgb), 32'(er));
    chk({tag, ".rv"}, 32'(sif.rgb_valid), 32'(vld));
  endtask

  initial begin
    idle();
    sif.frame_start = 1'b0;
    sif.pos_h = '0; sif.pos_v = '0; sif.spr_en = '0; sif.anim_en = '0;
    for (int i = 0; i < 4; i++) pix_val[i] = 12'h000;
    repeat (2) @(negedge clk);
    chk("rst.rgb", 32'(sif.rgb), 32'd0);
    chk("rst.rv", 32'(sif.rgb_valid), 32'd0);
    chk("rst.col", 32'(sif.collide), 32'd0);
    chk("rst.addr0", 32'(sif.spr_addr[0]), 32'd0);
    rst = 1'b1;

    // Basic placement, box edges and latency
    set_spr(0, 100, 50, 1, 0, 12'h123);
    fs(1);
    probe("base.l",   0, 100, 50, 1, 0,   12'h123);
    probe("base.r",   0, 119, 50, 1, 19,  12'h123);
    probe("base.out", 0, 120, 50, 1, 0,   12'h000);
    probe("base.pre", 0, 99,  50, 1, 0,   12'h000);
    probe("base.bot", 0, 105, 69, 1, 385, 12'h123);
    probe("base.v70", 0, 105, 70, 1, 0,   12'h000);

    // Animation from a clean reset
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    set_spr(0, 100, 50,  1, 1, 12'h123);
    set_spr(1, 300, 100, 1, 0, 12'h0A5);
    fs(8);
    probe("anim8",    0, 100, 50,  1, 400, 12'h123);
    probe("anim8.s1", 1, 300, 100, 1, 0,   12'h0A5);
    fs(8);
    probe("anim16",   0, 100, 50,  1, 800, 12'h123);
    fs(16);
    probe("anim32",   0, 100, 50,  1, 0,   12'h123);
    fs(8);
    probe("anim40",   0, 100, 50,  1, 400, 12'h123);

    // Key transparency, priority and collisions (sprite 0 now frozen on frame 1)
    set_spr(0, 200, 200, 1, 0, 12'hF0F);
    set_spr(1, 200, 200, 1, 0, 12'h0A5);
    fs(1);
    chk("col.none", 32'(sif.collide), 32'd0);
    probe("key", 1, 205, 203, 1, 65, 12'h0A5);
    pix_val[0] = 12'hF00;
    probe("prio", 0, 205, 203, 1, 465, 12'hF00);
    fs(1);
    chk("col.hit", 32'(sif.collide), 32'h3);
    fs(1);
    chk("col.clear", 32'(sif.collide), 32'd0);
    probe("prio2", 1, 205, 203, 1, 65, 12'hF00);
    fs(1);
    chk("col.hit2", 32'(sif.collide), 32'h3);

    // Async reset in the middle of an active line
    @(negedge clk);
    sif.h_cnt = 10'd205; sif.v_cnt = 10'd203; sif.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold.rgb", 32'(sif.rgb), 32'hF00);
    chk("hold.rv", 32'(sif.rgb_valid), 32'd1);
    chk("hold.a0", 32'(sif.spr_addr[0]), 32'd465);
    chk("hold.a1", 32'(sif.spr_addr[1]), 32'd65);
    #2 rst = 1'b0;
    #1;
    chk("ar.rgb", 32'(sif.rgb), 32'd0);
    chk("ar.rv", 32'(sif.rgb_valid), 32'd0);
    chk("ar.a0", 32'(sif.spr_addr[0]), 32'd0);
    chk("ar.a1", 32'(sif.spr_addr[1]), 32'd0);
    chk("ar.col", 32'(sif.collide), 32'd0);
    idle();
    @(negedge clk); rst = 1'b1;

    // Frame index restarted at 0
    set_spr(0, 100, 50, 1, 0, 12'h123);
    sif.spr_en[1] = 1'b0;
    fs(1);
    probe("restart", 0, 100, 50, 1, 0, 12'h123);

    // Mid-frame position change must wait for the next frame_start
    sif.pos_h[0] = 10'd300;
    probe("tear.old",  0, 105, 52, 1, 45, 12'h123);
    probe("tear.none", 0, 305, 52, 1, 0,  12'h000);
    fs(1);
    probe("tear.new",  0, 305, 52, 1, 45, 12'h123);
    probe("tear.gone", 0, 105, 52, 1, 0,  12'h000);

    // Right-edge clip, no wrap to column 0, blanking forces rgb to 0
    sif.pos_h[0] = 10'd630;
    fs(1);
    probe("clip.r",      0, 639, 51, 1, 29, 12'h123);
    probe("clip.l",      0, 630, 50, 1, 0,  12'h123);
    probe("clip.nowrap", 0, 9,   51, 1, 0,  12'h000);
    probe("clip.blank",  0, 635, 51, 0, 25, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
